// File: rtl/darkmem_arb.sv
// darkmem_arb: shares one single-port RAM between fetch and data ports, one access at a time; ack 2 (write) or LAT+2 (read) cycles after the request is sampled.
// The losing requester holds REQ until its ACK; define DARKMEM_ARB_RR_EN for round-robin ties, otherwise the data port wins.
module darkmem_arb #(
  parameter int AW  = 9,
  parameter int LAT = 1
) (
  input  logic          XCLK,
  input  logic          XRES,
  input  logic          I_REQ,
  input  logic [31:0]   I_ADDR,
  output logic          I_ACK,
  output logic [31:0]   I_RDATA,
  input  logic          D_REQ,
  input  logic          D_RW,
  input  logic [31:0]   D_ADDR,
  input  logic [31:0]   D_WDATA,
  input  logic [3:0]    D_BE,
  output logic          D_ACK,
  output logic [31:0]   D_RDATA,
  output logic          M_EN,
  output logic [3:0]    M_WE,
  output logic [AW-1:0] M_ADDR,
  output logic [31:0]   M_WDATA,
  input  logic [31:0]   M_RDATA
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_CAPT, S_DONE} state_t;

  localparam logic [1:0] WAIT_INIT = 2'((LAT > 1) ? LAT - 2 : 0);

  state_t     state;
  logic       sel_d;
  logic       sel_wr;
  logic [1:0] wait_cnt;
  logic       grant_d;

  // Byte-offset bits and bits above the RAM depth alias onto the same word.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{I_ADDR[31:AW+2], I_ADDR[1:0], D_ADDR[31:AW+2], D_ADDR[1:0]};

`ifdef DARKMEM_ARB_RR_EN
  logic last_d;
  assign grant_d = D_REQ & (~I_REQ | ~last_d);
`else
  assign grant_d = D_REQ;
`endif

  always_ff @(posedge XCLK or posedge XRES) begin
    if (XRES) begin
      state    <= S_IDLE;
      sel_d    <= 1'b0;
      sel_wr   <= 1'b0;
      wait_cnt <= 2'd0;
      I_ACK    <= 1'b0;
      D_ACK    <= 1'b0;
      I_RDATA  <= 32'd0;
      D_RDATA  <= 32'd0;
      M_EN     <= 1'b0;
      M_WE     <= 4'd0;
      M_ADDR   <= '0;
      M_WDATA  <= 32'd0;
`ifdef DARKMEM_ARB_RR_EN
      last_d   <= 1'b1;
`endif
    end else begin
      M_EN  <= 1'b0;
      M_WE  <= 4'd0;
      I_ACK <= 1'b0;
      D_ACK <= 1'b0;
      case (state)
        S_IDLE: begin
          if (I_REQ || D_REQ) begin
            // Strobes are launched here so they are visible during ISSUE.
            sel_d  <= grant_d;
            sel_wr <= grant_d & D_RW;
            M_EN   <= 1'b1;
            M_ADDR <= grant_d ? D_ADDR[AW+1:2] : I_ADDR[AW+1:2];
            M_WE   <= (grant_d && D_RW) ? D_BE : 4'd0;
            if (grant_d) M_WDATA <= D_WDATA;
`ifdef DARKMEM_ARB_RR_EN
            last_d <= grant_d;
`endif
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (sel_wr) begin
            D_ACK <= 1'b1;
            state <= S_DONE;
          end else if (LAT > 1) begin
            wait_cnt <= WAIT_INIT;
            state    <= S_WAIT;
          end else begin
            state <= S_CAPT;
          end
        end
        S_WAIT: begin
          if (wait_cnt == 2'd0) state <= S_CAPT;
          else wait_cnt <= wait_cnt - 2'd1;
        end
        S_CAPT: begin
          if (sel_d) begin
            D_RDATA <= M_RDATA;
            D_ACK   <= 1'b1;
          end else begin
            I_RDATA <= M_RDATA;
            I_ACK   <= 1'b1;
          end
          state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
